// File: rtl/otl_cfg_cmd.sv
// otl_cfg_cmd
// Byte-stream command decoder in front of the configuration register memory.
// It parses opcode/address/data bytes from a valid/ready byte channel, issues
// memory writes and reads, and streams the response bytes back out.
//
// Commands:
//   0x57 addr d0..d(NB-1)  write, data LSB first, response 0x06
//   0x52 addr              read, response is NB data bytes, LSB first
//   other                  response 0x15 plus an err pulse
// An inter-byte timeout in ADDR/WDATA drops a half-received command.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   rx_data/valid/ready   command byte input channel
//   tx_data/valid/ready   response byte output channel
//   wraddr/wrdata/wrvalid/wrready  memory write port
//   rdaddr/rdready/rddata/rdvalid  memory read port (rdready is a strobe)
//   err                   one-cycle pulse on NAK or timeout
module otl_cfg_cmd #(
  parameter int DATAW = 32,
  parameter int ADDRW = 4,
  parameter int TMO   = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [ADDRW-1:0] wraddr,
  output logic [DATAW-1:0] wrdata,
  output logic             wrvalid,
  input  logic             wrready,
  output logic [ADDRW-1:0] rdaddr,
  output logic             rdready,
  input  logic [DATAW-1:0] rddata,
  input  logic             rdvalid,
  output logic             err
);

  localparam int NB = DATAW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  // Counter value seen in the TMO-th idle cycle after the last accepted byte.
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WCOMMIT,
    S_RREQ,
    S_RWAIT,
    S_RTX,
    S_ACK,
    S_NAK
  } state_t;

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [DATAW-1:0] sh_q, sh_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [ADDRW-1:0] wraddr_q, wraddr_d;
  logic [DATAW-1:0] wrdata_q, wrdata_d;
  logic             wrvalid_q, wrvalid_d;
  logic [ADDRW-1:0] rdaddr_q, rdaddr_d;
  logic             rdready_q, rdready_d;
  logic             err_q, err_d;

  logic rx_acc;
  logic tx_hs;
  logic tmo_hit;

  // rx_ready is a pure state decode so the sender never sees a
  // combinational path from its own rx_valid.
  assign rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                    (state_q == S_WDATA);

  assign rx_acc  = rx_valid && rx_ready;
  assign tx_hs   = tx_valid_q && tx_ready;
  assign tmo_hit = (TMO > 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    sh_d       = sh_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    wraddr_d   = wraddr_q;
    wrdata_d   = wrdata_q;
    wrvalid_d  = wrvalid_q;
    rdaddr_d   = rdaddr_q;
    rdready_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          tmo_d = '0;
          if (rx_data == OP_WR) begin
            is_wr_d = 1'b1;
            state_d = S_ADDR;
          end else if (rx_data == OP_RD) begin
            is_wr_d = 1'b0;
            state_d = S_ADDR;
          end else begin
            err_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_NAK;
            state_d    = S_NAK;
          end
        end
      end

      S_ADDR: begin
        if (rx_acc) begin
          tmo_d = '0;
          cnt_d = '0;
          if (is_wr_q) begin
            wraddr_d = rx_data[ADDRW-1:0];
            state_d  = S_WDATA;
          end else begin
            rdaddr_d  = rx_data[ADDRW-1:0];
            rdready_d = 1'b1;  // registered, so high for the RREQ cycle
            state_d   = S_RREQ;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WDATA: begin
        if (rx_acc) begin
          tmo_d = '0;
          wrdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            wrvalid_d = 1'b1;
            state_d   = S_WCOMMIT;
          end
        end else if (tmo_hit) begin
          // Abandon the partial word; wrvalid is never raised.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WCOMMIT: begin
        if (wrready) begin
          wrvalid_d  = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ACK;
          state_d    = S_ACK;
        end
      end

      S_RREQ: begin
        state_d = S_RWAIT;
      end

      S_RWAIT: begin
        if (rdvalid) begin
          // First byte goes straight to the output register; the shift
          // register holds the bytes still to come.
          tx_data_d  = rddata[7:0];
          sh_d       = rddata >> 8;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_RTX;
        end
      end

      S_RTX: begin
        if (tx_hs) begin
          if (cnt_q == CNT_LAST) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = sh_q[7:0];
            sh_d      = sh_q >> 8;
            cnt_d     = cnt_q + CW'(1);
          end
        end
      end

      S_ACK, S_NAK: begin
        if (tx_hs) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        wrvalid_d  = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      sh_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      wrvalid_q  <= 1'b0;
      rdaddr_q   <= '0;
      rdready_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      sh_q       <= sh_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
      wrvalid_q  <= wrvalid_d;
      rdaddr_q   <= rdaddr_d;
      rdready_q  <= rdready_d;
      err_q      <= err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign wraddr   = wraddr_q;
  assign wrdata   = wrdata_q;
  assign wrvalid  = wrvalid_q;
  assign rdaddr   = rdaddr_q;
  assign rdready  = rdready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_otl_cfg_cmd.sv
// Directed bench for otl_cfg_cmd (DATAW=32, ADDRW=4, TMO=16).
// A small memory model answers reads one cycle after rdready and applies
// writes on the wrvalid/wrready handshake. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_otl_cfg_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  wraddr;
  logic [31:0] wrdata;
  logic        wrvalid;
  logic        wrready;
  logic [3:0]  rdaddr;
  logic        rdready;
  logic [31:0] rddata = 32'h0;
  logic        rdvalid = 1'b0;
  logic        err;

  int errs = 0;
  int checks = 0;

  logic [31:0] mem [16] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                            32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                            32'h10000008, 32'h10000009, 32'h1000000A, 32'h1000000B,
                            32'h1000000C, 32'h1000000D, 32'h1000000E, 32'h1000000F};
  logic [7:0] tx_log [$];
  int wr_cnt = 0;
  int err_cnt = 0;

  // All outputs packed, for reset-value checks: rx_ready is the MSB.
  logic [52:0] outs;
  assign outs = {rx_ready, tx_valid, tx_data, wrvalid, wraddr, wrdata,
                 rdaddr, rdready, err};
  localparam logic [52:0] OUTS_RST = {1'b1, 52'd0};

  otl_cfg_cmd #(.DATAW(32), .ADDRW(4), .TMO(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wraddr(wraddr), .wrdata(wrdata), .wrvalid(wrvalid), .wrready(wrready),
    .rdaddr(rdaddr), .rdready(rdready), .rddata(rddata), .rdvalid(rdvalid),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdvalid <= reset ? rdready : 1'b0;
    rddata  <= mem[rdaddr];
    if (wrvalid && wrready) begin
      mem[wraddr] <= wrdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (err) err_cnt <= err_cnt + 1;
  end

  // Present one byte and hold it until accepted; returns on the falling
  // edge after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, output int waited);
    rx_data = b;
    rx_valid = 1'b1;
    waited = 0;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checks++; errs++;
      $display("FAIL send_byte %02h: rx_ready never rose", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    send_byte(b, w);
  endtask

  task automatic pop_tx(output logic [7:0] b);
    int n = 0;
    while (tx_log.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_log.size() == 0) begin
      checks++; errs++;
      b = 8'hxx;
      $display("FAIL pop_tx: no response byte within bound");
    end else begin
      b = tx_log.pop_front();
    end
  endtask

  task automatic pop_word(output logic [31:0] w);
    logic [7:0] b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      pop_tx(b);
      w[8*i +: 8] = b;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b1; wrready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== OUTS_RST) begin
      errs++; $display("FAIL reset_hold: outs=%h expected=%h", outs, OUTS_RST);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (outs !== OUTS_RST) begin
      errs++; $display("FAIL reset_release: outs=%h expected=%h", outs, OUTS_RST);
    end
  endtask

  task automatic test_write;
    int wc0 = wr_cnt;
    tx_log.delete();
    send(8'h57); send(8'h03); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    checks++;
    if ({wrvalid, wraddr, wrdata, rx_ready} !== {1'b1, 4'h3, 32'hDEADBEEF, 1'b0}) begin
      errs++; $display("FAIL write_commit: wrvalid=%b wraddr=%h wrdata=%h rx_ready=%b expected 1 3 deadbeef 0",
                       wrvalid, wraddr, wrdata, rx_ready);
    end
    @(negedge clk);
    checks++;
    if ({wrvalid, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h06}) begin
      errs++; $display("FAIL write_ack: wrvalid=%b tx_valid=%b tx_data=%h expected 0 1 06",
                       wrvalid, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_log.size() != 1 || wr_cnt != wc0 + 1 || mem[3] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL write_done: tx_valid=%b log=%0d writes=%0d mem3=%h expected 0 1 1 deadbeef",
                       tx_valid, tx_log.size(), wr_cnt - wc0, mem[3]);
    end
    tx_log.delete();
  endtask

  task automatic test_read;
    logic [31:0] w;
    tx_log.delete();
    send(8'h52); send(8'h03);
    checks++;
    if ({rdready, rdaddr} !== {1'b1, 4'h3}) begin
      errs++; $display("FAIL read_req: rdready=%b rdaddr=%h expected 1 3", rdready, rdaddr);
    end
    @(negedge clk);
    checks++;
    if ({rdready, tx_valid} !== 2'b00) begin
      errs++; $display("FAIL read_wait: rdready=%b tx_valid=%b expected 0 0", rdready, tx_valid);
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hEF}) begin
      errs++; $display("FAIL read_first: tx_valid=%b tx_data=%h expected 1 ef", tx_valid, tx_data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_log.size() != 4) begin
      errs++; $display("FAIL read_len: tx_valid=%b bytes=%0d expected 0 4", tx_valid, tx_log.size());
    end
    pop_word(w);
    checks++;
    if (w !== 32'hDEADBEEF) begin
      errs++; $display("FAIL read_data: got=%h expected=deadbeef", w);
    end
  endtask

  task automatic test_bad_opcode;
    logic [7:0] b;
    logic [31:0] w;
    int e0 = err_cnt;
    tx_log.delete();
    send(8'h41);
    checks++;
    if ({err, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h15}) begin
      errs++; $display("FAIL nak: err=%b tx_valid=%b tx_data=%h expected 1 1 15", err, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errs++; $display("FAIL nak_pulse: err=%b expected 0", err);
    end
    send(8'h52); send(8'h00);
    pop_tx(b);
    checks++;
    if (b !== 8'h15) begin
      errs++; $display("FAIL nak_byte: got=%h expected=15", b);
    end
    pop_word(w);
    checks++;
    if (w !== 32'h10000000 || err_cnt != e0 + 1) begin
      errs++; $display("FAIL after_nak: data=%h errs=%0d expected 10000000 1", w, err_cnt - e0);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    int wc0 = wr_cnt;
    logic [31:0] w;
    tx_log.delete();
    send(8'h57); send(8'h05); send(8'h11);
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errs++; $display("FAIL timeout_cycles: got=%0d expected=16", n);
    end
    checks++;
    if (wr_cnt != wc0 || tx_log.size() != 0 || wrvalid !== 1'b0 || rx_ready !== 1'b1) begin
      errs++; $display("FAIL timeout_quiet: writes=%0d tx=%0d wrvalid=%b rx_ready=%b expected 0 0 0 1",
                       wr_cnt - wc0, tx_log.size(), wrvalid, rx_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errs++; $display("FAIL timeout_pulse: err=%b expected 0", err);
    end
    send(8'h52); send(8'h05);
    pop_word(w);
    checks++;
    if (w !== 32'h10000005) begin
      errs++; $display("FAIL timeout_readback: got=%h expected=10000005", w);
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int bad = 0;
    logic [31:0] w;
    tx_log.delete();
    tx_ready = 1'b0;
    send(8'h52); send(8'h03);
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hEF || rx_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL bp_hold: unstable cycles=%0d expected 0", bad);
    end
    tx_ready = 1'b1;
    pop_word(w);
    repeat (3) @(negedge clk);
    checks++;
    if (w !== 32'hDEADBEEF || tx_log.size() != 0) begin
      errs++; $display("FAIL bp_data: got=%h extra=%0d expected deadbeef 0", w, tx_log.size());
    end
  endtask

  task automatic test_gaps;
    logic [7:0] seq [6] = '{8'h57, 8'h07, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    logic [7:0] b;
    logic [31:0] w;
    int bad = 0;
    tx_log.delete();
    wrready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      if ({wrvalid, wraddr, wrdata} !== {1'b1, 4'h7, 32'hCAFEF00D}) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errs++; $display("FAIL wr_hold: unstable cycles=%0d expected 0", bad);
    end
    wrready = 1'b1;
    pop_tx(b);
    checks++;
    if (b !== 8'h06) begin
      errs++; $display("FAIL gap_ack: got=%h expected=06", b);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send(8'h52);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    send(8'h07);
    pop_word(w);
    checks++;
    if (w !== 32'hCAFEF00D) begin
      errs++; $display("FAIL gap_read: got=%h expected=cafef00d", w);
    end
  endtask

  task automatic test_back_to_back;
    int waited;
    logic [7:0] b;
    logic [31:0] w;
    tx_log.delete();
    send(8'h57); send(8'h02); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send_byte(8'h52, waited);
    checks++;
    if (waited != 2) begin
      errs++; $display("FAIL b2b_stall: waited=%0d expected=2", waited);
    end
    send(8'h02);
    pop_tx(b);
    pop_word(w);
    checks++;
    if (b !== 8'h06 || w !== 32'h11223344) begin
      errs++; $display("FAIL b2b_resp: ack=%h data=%h expected 06 11223344", b, w);
    end
  endtask

  task automatic test_reset_mid;
    int wc0 = wr_cnt;
    logic [31:0] w;
    tx_log.delete();
    send(8'h57); send(8'h01); send(8'hAA);
    checks++;
    if ({wraddr, wrdata[7:0]} !== {4'h1, 8'hAA}) begin
      errs++; $display("FAIL pre_reset: wraddr=%h wrdata=%h expected 1 xxxxxxaa", wraddr, wrdata);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== OUTS_RST) begin
      errs++; $display("FAIL reset_async: outs=%h expected=%h", outs, OUTS_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h52); send(8'h01);
    pop_word(w);
    checks++;
    if (w !== 32'h10000001 || wr_cnt != wc0) begin
      errs++; $display("FAIL reset_readback: got=%h writes=%0d expected 10000001 0", w, wr_cnt - wc0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
